// File: rtl/serial_cmd_pkg.sv
// Shared opcodes, FSM state encoding and sizing helpers for the serial command engine.
package serial_cmd_pkg;

   localparam logic [7:0] OP_VERSION = 8'h00;
   localparam logic [7:0] OP_WRITE   = 8'h01;
   localparam logic [7:0] OP_READ    = 8'h02;
   localparam logic [7:0] OP_HISTO   = 8'h03;
   localparam logic [7:0] OP_STROBE  = 8'h04;

   typedef enum logic [2:0] {IDLE, ARGS, EXEC, TX_LOAD, TX_WAIT} state_t;

   function automatic int args_for(input logic [7:0] opcode, input int reg_bytes);
      case (opcode)
         OP_WRITE:           return 1 + reg_bytes;
         OP_READ, OP_STROBE: return 1;
         default:            return 0;
      endcase
   endfunction

   function automatic logic op_known(input logic [7:0] opcode);
      return opcode <= OP_STROBE;
   endfunction

   function automatic int txbuf_depth(input int reg_bytes, input int num_histos);
      int d;
      d = 1;
      if (reg_bytes > d) d = reg_bytes;
      if (num_histos * 4 > d) d = num_histos * 4;
      return d;
   endfunction

   localparam int TXBUF_DEPTH = txbuf_depth(4, 8);

endpackage

// File: rtl/serial_tx_sequencer.sv
// Holds a reply snapshot and feeds it byte by byte to the UART transmitter.
module serial_tx_sequencer
   import serial_cmd_pkg::*;
#(
   parameter int DEPTH = TXBUF_DEPTH,
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 load,
   input  logic [DEPTH*8-1:0]   load_data,
   input  logic [IW-1:0]        load_last,
   input  logic                 tx_busy,
   output logic                 tx_start,
   output logic [7:0]           tx_data,
   output logic                 done
);

   logic [7:0]    buf_reg [DEPTH];
   state_t        state_reg;
   logic [IW-1:0] idx_reg;
   logic [IW-1:0] last_reg;
   logic          first_reg;

   always_ff @(posedge clk) begin
      if (load) begin
         for (int k = 0; k < DEPTH; k++) buf_reg[k] <= load_data[k*8 +: 8];
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg <= IDLE;
         idx_reg   <= '0;
         last_reg  <= '0;
         first_reg <= 1'b0;
         tx_start  <= 1'b0;
         tx_data   <= 8'h00;
         done      <= 1'b0;
      end else begin
         tx_start <= 1'b0;
         done     <= 1'b0;
         case (state_reg)
            IDLE: if (load) begin
               idx_reg   <= '0;
               last_reg  <= load_last;
               state_reg <= TX_LOAD;
            end
            TX_LOAD: if (!tx_busy) begin
               tx_data   <= buf_reg[idx_reg];
               tx_start  <= 1'b1;
               first_reg <= 1'b1;
               state_reg <= TX_WAIT;
            end
            TX_WAIT: begin
               // tx_busy only becomes meaningful one cycle after the launch
               if (first_reg) begin
                  first_reg <= 1'b0;
               end else if (!tx_busy) begin
                  if (idx_reg == last_reg) begin
                     done      <= 1'b1;
                     state_reg <= IDLE;
                  end else begin
                     idx_reg   <= idx_reg + IW'(1);
                     state_reg <= TX_LOAD;
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/serial_cmd_engine.sv
// UART command decoder: register bank writes/readback, strobes, histogram snapshot replies.
module serial_cmd_engine
   import serial_cmd_pkg::*;
#(
   parameter logic [7:0] FW_VERSION = 8'h08,
   parameter int NUM_REGS    = 16,
   parameter int REG_BYTES   = 4,
   parameter logic [NUM_REGS*REG_BYTES*8-1:0] REG_RESET = '0,
   parameter int NUM_HISTOS  = 8,
   parameter int NUM_STROBES = 8,
   parameter int RX_TIMEOUT  = 50000000
) (
   input  logic                            clk,
   input  logic                            rstn,
   input  logic                            rx_ready,
   input  logic [7:0]                      rx_data,
   input  logic                            tx_busy,
   output logic                            tx_start,
   output logic [7:0]                      tx_data,
   input  logic [NUM_HISTOS*32-1:0]        histos,
   output logic                            resethist,
   output logic [NUM_REGS*REG_BYTES*8-1:0] regs,
   output logic [NUM_REGS-1:0]             reg_wr,
   output logic [NUM_STROBES-1:0]          strobe,
   output logic [7:0]                      err_count
);

   localparam int RW        = REG_BYTES * 8;
   localparam int BUF_DEPTH = txbuf_depth(REG_BYTES, NUM_HISTOS);
   localparam int IW        = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int ARG_DEPTH = 1 + REG_BYTES;
   localparam int CW        = $clog2(ARG_DEPTH);
   localparam int TW        = $clog2(RX_TIMEOUT + 1);

   state_t          state_reg;
   logic [7:0]      op_reg;
   logic [CW-1:0]   cnt_reg;
   logic [TW-1:0]   tmo_reg;
   logic [7:0]      err_reg;
   logic            resethist_reg;
   logic [7:0]      arg_reg [ARG_DEPTH];

   logic [7:0]           addr;
   logic                 last_arg, tmo_hit, addr_ok, index_ok, load, done;
   logic                 err_a, err_b;
   logic [8:0]           err_sum;
   logic [RW-1:0]        wdata, rdata;
   logic [BUF_DEPTH*8-1:0] load_data;
   logic [IW-1:0]        load_last;

   assign addr     = arg_reg[0];
   assign last_arg = 32'(cnt_reg) == args_for(op_reg, REG_BYTES) - 1;
   assign tmo_hit  = tmo_reg == TW'(RX_TIMEOUT);
   assign addr_ok  = 32'(addr) < NUM_REGS;
   assign index_ok = 32'(addr) < NUM_STROBES;
   assign load     = (state_reg == EXEC) &&
                     (op_reg == OP_VERSION || op_reg == OP_HISTO || (op_reg == OP_READ && addr_ok));

   // Two error sources can coincide in EXEC (bad address plus a dropped byte)
   always_comb begin
      err_a = rx_ready && (state_reg == EXEC || state_reg == TX_WAIT);
      err_b = 1'b0;
      case (state_reg)
         IDLE: err_b = rx_ready && !op_known(rx_data);
         ARGS: err_b = tmo_hit;
         EXEC: begin
            if (op_reg == OP_WRITE || op_reg == OP_READ) err_b = !addr_ok;
            else if (op_reg == OP_STROBE)                err_b = !index_ok;
         end
         default: err_b = 1'b0;
      endcase
      err_sum = {1'b0, err_reg} + {8'b0, err_a} + {8'b0, err_b};
   end

   always_comb begin
      wdata = '0;
      for (int b = 0; b < REG_BYTES; b++) wdata[b*8 +: 8] = arg_reg[b+1];
      rdata = '0;
      for (int k = 0; k < NUM_REGS; k++) begin
         if (32'(addr) == k) rdata = regs[k*RW +: RW];
      end
      load_data = '0;
      load_last = '0;
      case (op_reg)
         OP_READ: begin
            load_data[RW-1:0] = rdata;
            load_last         = IW'(REG_BYTES - 1);
         end
         OP_HISTO: begin
            load_data[NUM_HISTOS*32-1:0] = histos;
            load_last                    = IW'(NUM_HISTOS * 4 - 1);
         end
         default: load_data[7:0] = FW_VERSION;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_reg     <= IDLE;
         op_reg        <= 8'h00;
         cnt_reg       <= '0;
         tmo_reg       <= '0;
         err_reg       <= 8'h00;
         resethist_reg <= 1'b0;
      end else begin
         resethist_reg <= 1'b0;
         err_reg       <= err_sum[8] ? 8'hFF : err_sum[7:0];
         case (state_reg)
            IDLE: if (rx_ready && op_known(rx_data)) begin
               op_reg  <= rx_data;
               cnt_reg <= '0;
               tmo_reg <= '0;
               if (args_for(rx_data, REG_BYTES) == 0) begin
                  state_reg     <= EXEC;
                  // high during EXEC, the cycle whose closing edge takes the snapshot
                  resethist_reg <= (rx_data == OP_HISTO);
               end else begin
                  state_reg <= ARGS;
               end
            end
            ARGS: begin
               if (tmo_hit) begin
                  state_reg <= IDLE;
               end else if (rx_ready) begin
                  tmo_reg <= '0;
                  cnt_reg <= cnt_reg + CW'(1);
                  if (last_arg) state_reg <= EXEC;
               end else begin
                  tmo_reg <= tmo_reg + TW'(1);
               end
            end
            EXEC:    state_reg <= load ? TX_WAIT : IDLE;
            TX_WAIT: if (done) state_reg <= IDLE;
            default: state_reg <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state_reg == ARGS && rx_ready && !tmo_hit) arg_reg[cnt_reg] <= rx_data;
   end

   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [RW-1:0] value_reg;
      logic          wr_reg;
      logic          hit;
      assign hit = (state_reg == EXEC) && (op_reg == OP_WRITE) && (32'(addr) == gi);
      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            value_reg <= REG_RESET[gi*RW +: RW];
            wr_reg    <= 1'b0;
         end else begin
            wr_reg <= hit;
            if (hit) value_reg <= wdata;
         end
      end
      assign regs[gi*RW +: RW] = value_reg;
      assign reg_wr[gi]        = wr_reg;
   end

   for (genvar gi = 0; gi < NUM_STROBES; gi++) begin : g_strobe
      logic pulse_reg;
      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) pulse_reg <= 1'b0;
         else       pulse_reg <= (state_reg == EXEC) && (op_reg == OP_STROBE) && (32'(addr) == gi);
      end
      assign strobe[gi] = pulse_reg;
   end

   serial_tx_sequencer #(.DEPTH(BUF_DEPTH)) u_tx (
      .clk       (clk),
      .rstn      (rstn),
      .load      (load),
      .load_data (load_data),
      .load_last (load_last),
      .tx_busy   (tx_busy),
      .tx_start  (tx_start),
      .tx_data   (tx_data),
      .done      (done)
   );

   assign resethist = resethist_reg;
   assign err_count = err_reg;

endmodule

// File: tb/tb_serial_cmd_engine.sv
// Directed bench for serial_cmd_engine with a small UART transmitter model.
module tb_serial_cmd_engine;

   localparam int NR = 16;
   localparam int RB = 4;
   localparam int NH = 8;
   localparam int NS = 8;

   function automatic logic [NR*RB*8-1:0] make_img();
      logic [NR*RB*8-1:0] r;
      r = '0;
      for (int k = 0; k < NR; k++) r[k*32 +: 32] = 32'hA000_0000 | 32'(k);
      return r;
   endfunction

   localparam logic [NR*RB*8-1:0] RST_IMG = make_img();

   logic             clk = 1'b0;
   logic             rstn = 1'b0;
   logic             rx_ready = 1'b0;
   logic [7:0]       rx_data = 8'h00;
   logic             tx_busy = 1'b0;
   logic [NH*32-1:0] histos = '0;
   logic             tx_start;
   logic [7:0]       tx_data;
   logic             resethist;
   logic [NR*RB*8-1:0] regs;
   logic [NR-1:0]    reg_wr;
   logic [NS-1:0]    strobe;
   logic [7:0]       err_count;

   serial_cmd_engine #(
      .FW_VERSION (8'h08),
      .NUM_REGS   (NR),
      .REG_BYTES  (RB),
      .REG_RESET  (RST_IMG),
      .NUM_HISTOS (NH),
      .NUM_STROBES(NS),
      .RX_TIMEOUT (100)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .rx_ready  (rx_ready),
      .rx_data   (rx_data),
      .tx_busy   (tx_busy),
      .tx_start  (tx_start),
      .tx_data   (tx_data),
      .histos    (histos),
      .resethist (resethist),
      .regs      (regs),
      .reg_wr    (reg_wr),
      .strobe    (strobe),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   logic [7:0] tx_q [$];
   int busy_len = 2;
   int busy_left = 0;
   int overlap = 0;
   int wr3 = 0, wr2 = 0, stb = 0, rh = 0;
   logic [31:0] hm [NH];
   logic [31:0] w;

   // Transmitter: captures each launched byte and stays busy for busy_len cycles
   initial forever begin
      @(posedge clk);
      #1;
      if (busy_left > 0) begin
         busy_left--;
         if (busy_left == 0) tx_busy = 1'b0;
      end
      if (tx_start) begin
         tx_q.push_back(tx_data);
         if (tx_busy) overlap++;
         tx_busy   = 1'b1;
         busy_left = busy_len;
      end
   end

   initial forever begin
      @(negedge clk);
      if (reg_wr[3]) wr3++;
      if (reg_wr[2]) wr2++;
      if (strobe != '0) stb++;
      if (resethist) rh++;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_ready = 1'b1;
      rx_data  = b;
      @(negedge clk);
      rx_ready = 1'b0;
   endtask

   task automatic wait_bytes(input int n, input int budget);
      for (int i = 0; i < budget && tx_q.size() < n; i++) @(negedge clk);
      repeat (busy_len + 8) @(negedge clk);
      check("reply_len", tx_q.size(), n);
   endtask

   initial begin
      rstn = 1'b0;
      tick(3);
      check("rst_tx_start", tx_start, 0);
      check("rst_tx_data", tx_data, 0);
      check("rst_resethist", resethist, 0);
      check("rst_reg_wr", reg_wr, 0);
      check("rst_strobe", strobe, 0);
      check("rst_err", err_count, 0);
      for (int k = 0; k < NR; k++) check("rst_reg", regs[k*32 +: 32], RST_IMG[k*32 +: 32]);
      rstn = 1'b1;
      tick(2);

      // VERSION and first-byte latency
      tx_q.delete();
      send_byte(8'h00);
      check("ver_lat0", tx_start, 0);
      tick(1);
      check("ver_lat1", tx_start, 0);
      tick(1);
      check("ver_lat2", tx_start, 1);
      wait_bytes(1, 100);
      check("ver_byte", tx_q[0], 8'h08);
      check("ver_err", err_count, 0);

      // WRITE reg 3
      send_byte(8'h01); send_byte(8'h03); send_byte(8'hEF);
      send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
      check("wr_lat0", reg_wr, 0);
      tick(1);
      check("wr_pulse", reg_wr, 16'h0008);
      check("wr_val", regs[3*32 +: 32], 32'hDEADBEEF);
      tick(1);
      check("wr_end", reg_wr, 0);
      check("wr_neighbor", regs[4*32 +: 32], 32'hA0000004);

      // READ reg 3, short then long busy
      w = 32'hDEADBEEF;
      tx_q.delete();
      send_byte(8'h02); send_byte(8'h03);
      wait_bytes(4, 200);
      for (int i = 0; i < 4; i++) check("rd_byte", tx_q[i], w[i*8 +: 8]);
      busy_len = 20;
      tx_q.delete();
      send_byte(8'h02); send_byte(8'h03);
      wait_bytes(4, 400);
      for (int i = 0; i < 4; i++) check("rd_slow_byte", tx_q[i], w[i*8 +: 8]);
      busy_len = 2;
      check("wr3_pulses", wr3, 1);
      check("tx_overlap", overlap, 0);

      // HISTO snapshot alignment
      histos[31:0] = 32'h11223344;
      for (int k = 1; k < NH; k++) histos[k*32 +: 32] = 32'(k);
      hm[0] = 32'h11223344;
      for (int k = 1; k < NH; k++) hm[k] = 32'(k);
      hm[2] = 32'h22;
      tx_q.delete();
      send_byte(8'h03);
      check("rh_snap", resethist, 1);
      histos[2*32 +: 32] = 32'h22;
      tick(1);
      check("rh_end", resethist, 0);
      histos[1*32 +: 32] = 32'hFF;
      wait_bytes(32, 1000);
      for (int i = 0; i < 32; i++) check("histo_byte", tx_q[i], hm[i/4][(i%4)*8 +: 8]);
      check("rh_count", rh, 1);

      // STROBE valid and out of range
      send_byte(8'h04); send_byte(8'h05);
      check("stb_lat0", strobe, 0);
      tick(1);
      check("stb_pulse", strobe, 8'h20);
      tick(1);
      check("stb_end", strobe, 0);
      send_byte(8'h04); send_byte(8'h09);
      tick(3);
      check("stb_count", stb, 1);
      check("stb_err", err_count, 1);

      // Argument timeout
      send_byte(8'h01); send_byte(8'h02);
      tick(100);
      check("tmo_early", err_count, 1);
      tick(1);
      check("tmo_err", err_count, 2);
      check("tmo_reg2", regs[2*32 +: 32], 32'hA0000002);
      check("tmo_wr2", wr2, 0);
      tx_q.delete();
      send_byte(8'h00);
      wait_bytes(1, 100);
      check("tmo_ver", tx_q[0], 8'h08);

      // Unknown opcode and saturation
      send_byte(8'h07);
      tick(1);
      check("unk_err", err_count, 3);
      for (int i = 0; i < 260; i++) send_byte(8'hFF);
      tick(1);
      check("err_sat", err_count, 255);

      // Reset during third HISTO byte
      busy_len = 5;
      tx_q.delete();
      send_byte(8'h03);
      for (int i = 0; i < 500 && tx_q.size() < 3; i++) begin
         @(posedge clk);
         #2;
      end
      check("mid_seen3", tx_q.size(), 3);
      rstn = 1'b0;
      #1;
      check("mid_tx_start", tx_start, 0);
      tick(3);
      rstn = 1'b1;
      tick(60);
      check("mid_no_more", tx_q.size(), 3);
      check("mid_err", err_count, 0);
      check("mid_reg3", regs[3*32 +: 32], 32'hA0000003);
      tx_q.delete();
      send_byte(8'h00);
      wait_bytes(1, 100);
      check("mid_ver", tx_q[0], 8'h08);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
